// File: rtl/bus_fifo_stage_if.sv
// bus_if: 8-bit valid/ready handshake bundle.
//   master : drives data, valid; samples ready
//   slave  : samples data, valid; drives ready
interface bus_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bus_fifo_stage.sv
// bus_fifo_stage: DEPTH-entry, 8-bit FIFO between two valid/ready buses.
//
// Ports
//   clk      : rising-edge clock for all state
//   rst_n    : asynchronous active-low reset
//   up       : bus_if.slave, upstream side (data/valid in, ready out)
//   dn       : bus_if.master, downstream side (data/valid out, ready in)
//   level    : number of stored entries
//   xfer_cnt : saturating count of downstream transfers
//              (present only when BUS_FIFO_STAGE_CNT_EN is defined)
//
// Optional feature macro: BUS_FIFO_STAGE_CNT_EN
//
// Behaviour notes
//   up.ready is registered.  After each edge it equals (level < DEPTH),
//   using the level value that edge produced.  It is 0 while in reset.
//   dn.data and dn.valid are decoded from registered state only. This means
//   a word written at edge N becomes visible just after edge N, and nothing
//   passes combinationally from up to dn.
module bus_fifo_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bus_if.slave                     up,
  bus_if.master                    dn,
  output logic [$clog2(DEPTH):0]   level
`ifdef BUS_FIFO_STAGE_CNT_EN
  ,
  output logic [15:0]              xfer_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_fifo_stage: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_up_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_not_empty;

  assign w_not_empty = (r_level != '0);

  // r_up_ready is only ever 1 when level < DEPTH, so it alone gates writes.
  // A full FIFO therefore refuses a write even when a pop happens on the
  // same edge.
  assign w_push = up.valid & r_up_ready;
  assign w_pop  = dn.ready & w_not_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_up_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level    <= w_level_nxt;
      r_up_ready <= (w_level_nxt < FULL_LVL);
    end
  end

  // Storage is not reset.  Any stale contents are hidden because level == 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= up.data;
  end

  assign up.ready = r_up_ready;
  assign dn.valid = w_not_empty;
  assign dn.data  = w_not_empty ? r_mem[r_rd_ptr] : 8'h00;
  assign level    = r_level;

`ifdef BUS_FIFO_STAGE_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_pop && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: doc/bus_fifo_stage.md
BUS_FIFO_STAGE -- requirements
Module: bus_fifo_stage

Interface
REQ-001 Parameter: DEPTH, default 4, number of 8-bit entries; SHALL be a power of two and at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: up  bus_if.slave  8+1+1  upstream side; samples data and valid, drives ready.
REQ-005 Port: dn  bus_if.master  8+1+1  downstream side; drives data and valid, samples ready.
REQ-006 Port: level  output  $clog2(DEPTH)+1  number of entries currently stored.
REQ-007 Interface: the block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-008 A transfer on either side SHALL occur on a rising clk edge where valid and ready are both 1 on that side.
REQ-009 An upstream transfer SHALL write up.data at the write pointer, advance the write pointer modulo DEPTH and increment level.
REQ-010 A downstream transfer SHALL advance the read pointer modulo DEPTH and decrement level.
REQ-011 A simultaneous upstream and downstream transfer SHALL leave level unchanged and advance both pointers.
REQ-012 dn.valid SHALL equal (level != 0); dn.data SHALL equal the entry at the read pointer, or 8'h00 when level == 0.
REQ-013 Latency: a word accepted upstream at edge N SHALL appear on dn.data with dn.valid=1 after edge N; there is no combinational up-to-dn path.
REQ-014 up.ready SHALL be a registered output; after each edge it SHALL equal (level < DEPTH), with level taken as the post-edge value.
REQ-015 Full boundary: when level == DEPTH, up.ready SHALL be 0 and no write SHALL occur, even if dn.ready=1 in the same cycle.
REQ-016 Empty boundary: when level == 0, no read SHALL occur, and dn.ready SHALL have no effect.
REQ-017 Pointer wrap: the pointers SHALL wrap from DEPTH-1 to 0 with no loss or reordering; output order SHALL be strict FIFO.
REQ-018 dn.data and dn.valid SHALL stay stable while dn.valid=1 and dn.ready=0.
REQ-019 The block SHALL never drive up.data, up.valid or dn.ready.

Reset
REQ-020 On rst_n low, pointers SHALL be 0, level SHALL be 0, up.ready SHALL be 0, dn.valid SHALL be 0 and dn.data SHALL be 8'h00, all immediately and without waiting for a clock edge.
REQ-021 up.ready SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-022 Reset asserted mid-operation SHALL discard all stored entries; storage contents need no reset, because they are masked by level == 0.

Configuration
REQ-023 Macro BUS_FIFO_STAGE_CNT_EN, when defined, SHALL add port xfer_cnt  output  16  count of downstream transfers.
REQ-024 With BUS_FIFO_STAGE_CNT_EN defined:
- xfer_cnt SHALL reset to 0.
- xfer_cnt SHALL increment on each downstream transfer.
- xfer_cnt SHALL saturate at 16'hFFFF.
REQ-025 Without BUS_FIFO_STAGE_CNT_EN, neither the port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-026 Single word: reset, then up.valid=1 with data 8'hAA for 1 cycle and dn.ready=0 -> dn.valid=1, dn.data=8'hAA and level=1 from the next cycle.
REQ-027 Fill: dn.ready=0, push 8'h01..8'h04 with DEPTH=4 -> level=4, up.ready=0, and a 5th word 8'h05 is not accepted.
REQ-028 Drain with wrap: after the fill, dn.ready=1 while pushing 8'h05..8'h08 -> output sequence is 01..08 in order, and level returns to 0.
REQ-029 Full with simultaneous pop: at level=4, up.valid=1 and dn.ready=1 -> one pop, no push, level=3, and up.ready=1 after the edge.
REQ-030 Reset mid-stream: rst_n low at level=2 -> dn.valid=0, level=0 and up.ready=0 immediately, and up.ready=1 one edge after release.
REQ-031 Counter (macro defined): 5 downstream transfers -> xfer_cnt=5; with xfer_cnt forced to 16'hFFFF, a further transfer leaves it at 16'hFFFF.
